s6_packetizer: RTL and testbench

- Cuts a fixed-length frame of NWORDS 64-bit words (e.g. one spectrum) into up to 16 consecutive packets of nwords_per_pkt words each.
- Packetization starts at word start_word of each frame.
- Each output word carries a data-valid flag, a 4-bit destination index and an end-of-frame/packet flag (eof).
- Sits between the frame-synchronous data path and the multi-destination 10GbE transmit stage.

---
 rtl/s6_pkt_pkg.sv | 23 ++
 rtl/s6_pkt_sched.sv | 96 +++++++++
 rtl/s6_packetizer.sv | 60 ++++++
 tb/tb_s6_packetizer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s6_pkt_pkg.sv
// Shared constants and helpers for the s6 packetizer: widths, packet limit and
// a constant-evaluable ceil(log2) used to size the frame index ports.
package s6_pkt_pkg;

  localparam int MAX_PKTS  = 16;
  localparam int PKT_CNT_W = 5;
  localparam int DST_W     = 4;
  localparam int DATA_W    = 64;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/s6_pkt_sched.sv
// Packet scheduler: tracks the frame index of the word on din, which packet is
// being built and the word inside it, and produces registered dv/eof/dst.
module s6_pkt_sched
  import s6_pkt_pkg::*;
#(
  parameter int NWORDS      = 128,
  parameter int NWORDS_BITS = clog2(NWORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   sync,
  input  logic [NWORDS_BITS-1:0] start_word,
  input  logic [NWORDS_BITS-1:0] nwords_per_pkt,
  input  logic [DST_W-1:0]       src_id,
  output logic                   dv,
  output logic                   eof,
  output logic [DST_W-1:0]       dst
);

  localparam int IDX_W = NWORDS_BITS + 1;
  // Wide enough for start_word + 16*nwords_per_pkt without wrapping.
  localparam int EXT_W = NWORDS_BITS + 5;
  localparam logic [EXT_W-1:0] NWORDS_EXT = EXT_W'(NWORDS);

  logic [IDX_W-1:0]       idx_r;
  logic [EXT_W-1:0]       off_r;
  logic [PKT_CNT_W-1:0]   pkt_cnt_r;
  logic [NWORDS_BITS-1:0] wcnt_r;
  logic                   armed_r;

  logic [EXT_W-1:0]       base_s;
  logic [EXT_W-1:0]       idx_ext_s;
  logic                   fits_s;
  logic                   in_pkt_s;
  logic                   last_s;

  assign base_s    = EXT_W'(start_word) + off_r;
  assign idx_ext_s = EXT_W'(idx_r);
  assign fits_s    = (base_s + EXT_W'(nwords_per_pkt)) <= NWORDS_EXT;

  // Classify the word currently on din against the packet being built.
  always_comb begin
    in_pkt_s = 1'b0;
    last_s   = 1'b0;
    if (armed_r && (idx_ext_s < NWORDS_EXT) && (nwords_per_pkt != {NWORDS_BITS{1'b0}}) &&
        (pkt_cnt_r < PKT_CNT_W'(MAX_PKTS)) && fits_s && (idx_ext_s >= base_s)) begin
      in_pkt_s = 1'b1;
      last_s   = (wcnt_r == (nwords_per_pkt - NWORDS_BITS'(1)));
    end else begin
      in_pkt_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  // Index/packet counters and registered flags; sync restarts the frame after
  // the word on the sync cycle has been classified with the old frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r     <= IDX_W'(NWORDS);
      off_r     <= {EXT_W{1'b0}};
      pkt_cnt_r <= {PKT_CNT_W{1'b0}};
      wcnt_r    <= {NWORDS_BITS{1'b0}};
      armed_r   <= 1'b0;
      dv        <= 1'b0;
      eof       <= 1'b0;
      dst       <= {DST_W{1'b0}};
    end else if (ce) begin
      dv  <= in_pkt_s;
      eof <= last_s;
      dst <= src_id + pkt_cnt_r[DST_W-1:0];
      if (sync) begin
        idx_r     <= {IDX_W{1'b0}};
        off_r     <= {EXT_W{1'b0}};
        pkt_cnt_r <= {PKT_CNT_W{1'b0}};
        wcnt_r    <= {NWORDS_BITS{1'b0}};
        armed_r   <= 1'b1;
      end else begin
        if (idx_ext_s < NWORDS_EXT) begin
          idx_r <= idx_r + IDX_W'(1);
        end
        if (last_s) begin
          wcnt_r    <= {NWORDS_BITS{1'b0}};
          pkt_cnt_r <= pkt_cnt_r + PKT_CNT_W'(1);
          off_r     <= off_r + EXT_W'(nwords_per_pkt);
        end else if (in_pkt_s) begin
          wcnt_r <= wcnt_r + NWORDS_BITS'(1);
        end
      end
    end else begin
      dv  <= 1'b0;
      eof <= 1'b0;
    end
  end

endmodule

// File: rtl/s6_packetizer.sv
// Frame packetizer top: latches per-frame controls at sync, registers the data
// word and hands packet scheduling to s6_pkt_sched.
module s6_packetizer
  import s6_pkt_pkg::*;
#(
  parameter int NWORDS      = 128,
  parameter int NWORDS_BITS = clog2(NWORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   sync,
  input  logic [DATA_W-1:0]      din,
  input  logic [NWORDS_BITS-1:0] start_word,
  input  logic [NWORDS_BITS-1:0] nwords_per_pkt,
  input  logic [DST_W-1:0]       src_id,
  output logic [DATA_W-1:0]      dout,
  output logic                   dv,
  output logic [DST_W-1:0]       dst,
  output logic                   eof
);

  logic [NWORDS_BITS-1:0] start_r;
  logic [NWORDS_BITS-1:0] npp_r;
  logic [DST_W-1:0]       src_r;

  // Data register plus control latch; controls only change at a sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout    <= {DATA_W{1'b0}};
      start_r <= {NWORDS_BITS{1'b0}};
      npp_r   <= {NWORDS_BITS{1'b0}};
      src_r   <= {DST_W{1'b0}};
    end else if (ce) begin
      dout <= din;
      if (sync) begin
        start_r <= start_word;
        npp_r   <= nwords_per_pkt;
        src_r   <= src_id;
      end
    end
  end

  s6_pkt_sched #(
    .NWORDS      (NWORDS),
    .NWORDS_BITS (NWORDS_BITS)
  ) u_sched (
    .clk            (clk),
    .rst            (rst),
    .ce             (ce),
    .sync           (sync),
    .start_word     (start_r),
    .nwords_per_pkt (npp_r),
    .src_id         (src_r),
    .dv             (dv),
    .eof            (eof),
    .dst            (dst)
  );

endmodule

// File: tb/tb_s6_packetizer.sv
// Self-checking bench for s6_packetizer: directed frames plus randomized
// traffic compared against an arithmetic packet model.
module tb_s6_packetizer;

  localparam int NWORDS = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        sync = 1'b0;
  logic [63:0] din = 64'd0;
  logic [6:0]  start_word = 7'd0;
  logic [6:0]  nwords_per_pkt = 7'd0;
  logic [3:0]  src_id = 4'd0;
  logic [63:0] dout;
  logic        dv;
  logic [3:0]  dst;
  logic        eof;

  int checks = 0;
  int errors = 0;

  int m_idx = NWORDS;
  int m_s = 0, m_n = 0, m_src = 0;
  bit m_armed = 1'b0;
  logic [63:0] exp_dout = 64'd0;
  logic        exp_dv = 1'b0, exp_eof = 1'b0;
  logic [3:0]  exp_dst = 4'd0;
  int cnt_dv, cnt_eof;

  s6_packetizer #(.NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync(sync), .din(din),
    .start_word(start_word), .nwords_per_pkt(nwords_per_pkt), .src_id(src_id),
    .dout(dout), .dv(dv), .dst(dst), .eof(eof)
  );

  always #5 clk = ~clk;

  // {dv, eof, dst} for frame index i: packet k = (i-s)/n must fit entirely.
  function automatic logic [5:0] ref_word(int i, int s, int n, int src);
    int k;
    logic v, e;
    logic [3:0] d;
    v = 1'b0; e = 1'b0; d = 4'd0;
    if (n > 0 && i >= s && i < NWORDS) begin
      k = (i - s) / n;
      if (k < 16 && s + (k + 1) * n <= NWORDS) begin
        v = 1'b1;
        e = (((i - s) % n) == n - 1);
        d = 4'((src + k) % 16);
      end
    end
    return {v, e, d};
  endfunction

  task automatic cycle(input logic s, input logic c, input logic [63:0] d);
    logic [5:0] r;
    @(negedge clk);
    sync = s; ce = c; din = d;
    if (c) begin
      exp_dout = d;
      r = m_armed ? ref_word(m_idx, m_s, m_n, m_src) : 6'd0;
      exp_dv = r[5]; exp_eof = r[4]; exp_dst = r[3:0];
      if (s) begin
        m_s = int'(start_word); m_n = int'(nwords_per_pkt); m_src = int'(src_id);
        m_idx = 0; m_armed = 1'b1;
      end else if (m_idx < NWORDS) begin
        m_idx++;
      end
    end else begin
      exp_dv = 1'b0; exp_eof = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx = NWORDS; m_armed = 1'b0; m_s = 0; m_n = 0; m_src = 0;
    exp_dout = 64'd0; exp_dv = 1'b0; exp_eof = 1'b0; exp_dst = 4'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ce = 1'b0; sync = 1'b1; din = 64'hdead_beef_0000_0001;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (dout !== 64'd0 || dv !== 1'b0 || eof !== 1'b0 || dst !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got dout=%0h dv=%b eof=%b dst=%0d, want all 0", dout, dv, eof, dst);
    end
    @(negedge clk);
    rst = 1'b0; sync = 1'b0; ce = 1'b0;
    cnt_dv = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
      if (dv !== 1'b0 || eof !== 1'b0) cnt_dv++;
      checks++;
      if (dout !== exp_dout || dv !== exp_dv || eof !== exp_eof) begin
        errors++;
        $display("FAIL pre_sync: got dout=%0h dv=%b eof=%b, want dout=%0h dv=%b eof=%b", dout, dv, eof, exp_dout, exp_dv, exp_eof);
      end
    end
    checks++;
    if (cnt_dv != 0) begin
      errors++;
      $display("FAIL pre_sync_count: got %0d flagged words, want 0", cnt_dv);
    end
  endtask

  // One sync followed by full frames of din = index; optional resync on word 127.
  task automatic test_frames(input string name, input int s, input int n, input int src,
                             input int frames, input int want_dv, input int want_eof);
    start_word = 7'(s); nwords_per_pkt = 7'(n); src_id = 4'(src);
    cycle(1'b1, 1'b1, 64'd127);
    cnt_dv = 0; cnt_eof = 0;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < NWORDS; i++) begin
        cycle(1'(i == NWORDS - 1 && f < frames - 1), 1'b1, 64'(i));
        cnt_dv += int'(dv); cnt_eof += int'(dv & eof);
        checks++;
        if (dout !== exp_dout || dv !== exp_dv || eof !== exp_eof || (exp_dv && dst !== exp_dst)) begin
          errors++;
          $display("FAIL %s: got dout=%0h dv=%b eof=%b dst=%0d, want dout=%0h dv=%b eof=%b dst=%0d",
                   name, dout, dv, eof, dst, exp_dout, exp_dv, exp_eof, exp_dst);
        end
      end
    end
    checks++;
    if (cnt_dv != want_dv || cnt_eof != want_eof) begin
      errors++;
      $display("FAIL %s_count: got dv=%0d eof=%0d, want dv=%0d eof=%0d", name, cnt_dv, cnt_eof, want_dv, want_eof);
    end
  endtask

  task automatic test_ce_gating();
    start_word = 7'd7; nwords_per_pkt = 7'd3; src_id = 4'd0;
    cycle(1'b1, 1'b1, 64'd127);
    cnt_dv = 0; cnt_eof = 0;
    for (int i = 0; i < NWORDS; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) cycle(1'b0, 1'b1, 64'(i));
        else         cycle(1'b1, 1'b0, {$urandom, $urandom});
        cnt_dv += int'(dv); cnt_eof += int'(dv & eof);
        checks++;
        if (dout !== exp_dout || dv !== exp_dv || eof !== exp_eof || (exp_dv && dst !== exp_dst)) begin
          errors++;
          $display("FAIL ce_gating: got dout=%0h dv=%b eof=%b dst=%0d, want dout=%0h dv=%b eof=%b dst=%0d",
                   dout, dv, eof, dst, exp_dout, exp_dv, exp_eof, exp_dst);
        end
      end
    end
    checks++;
    if (cnt_dv != 48 || cnt_eof != 16) begin
      errors++;
      $display("FAIL ce_gating_count: got dv=%0d eof=%0d, want dv=48 eof=16", cnt_dv, cnt_eof);
    end
  endtask

  task automatic test_mid_sync();
    logic seen;
    start_word = 7'd7; nwords_per_pkt = 7'd3; src_id = 4'd0;
    cycle(1'b1, 1'b1, 64'd127);
    cnt_eof = 0; seen = 1'b0;
    for (int i = 0; i < 21 + NWORDS; i++) begin
      cycle(1'(i == 20), 1'b1, 64'(i <= 20 ? i : i - 21));
      if (i <= 20) cnt_eof += int'(dv & eof);
      if (i > 20 && dv === 1'b1 && !seen) begin
        seen = 1'b1;
        checks++;
        if (dout !== 64'd7 || dst !== 4'd0) begin
          errors++;
          $display("FAIL mid_sync_first: got dout=%0d dst=%0d, want dout=7 dst=0", dout, dst);
        end
      end
      checks++;
      if (dout !== exp_dout || dv !== exp_dv || eof !== exp_eof || (exp_dv && dst !== exp_dst)) begin
        errors++;
        $display("FAIL mid_sync: got dout=%0h dv=%b eof=%b dst=%0d, want dout=%0h dv=%b eof=%b dst=%0d",
                 dout, dv, eof, dst, exp_dout, exp_dv, exp_eof, exp_dst);
      end
    end
    checks++;
    if (cnt_eof != 4 || !seen) begin
      errors++;
      $display("FAIL mid_sync_count: got eof=%0d restart=%b, want eof=4 restart=1", cnt_eof, seen);
    end
  endtask

  task automatic test_reset_mid_packet();
    start_word = 7'd7; nwords_per_pkt = 7'd3; src_id = 4'd0;
    cycle(1'b1, 1'b1, 64'd127);
    for (int i = 0; i < 31; i++) cycle(1'b0, 1'b1, 64'(i));
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; sync = 1'b0; din = 64'd31;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b1; din = 64'd32;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (dout !== 64'd0 || dv !== 1'b0 || eof !== 1'b0 || dst !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got dout=%0h dv=%b eof=%b dst=%0d, want all 0", dout, dv, eof, dst);
    end
    @(negedge clk);
    rst = 1'b0; sync = 1'b0; ce = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b1, 64'(33 + i));
      checks++;
      if (dout !== exp_dout || dv !== 1'b0 || eof !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after: got dout=%0h dv=%b eof=%b, want dout=%0h dv=0 eof=0", dout, dv, eof, exp_dout);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      start_word = 7'($urandom_range(0, 127));
      nwords_per_pkt = 7'($urandom_range(0, 20));
      src_id = 4'($urandom_range(0, 15));
      cycle(1'b1, 1'b1, {$urandom, $urandom});
      for (int i = 0; i < 170; i++) begin
        cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), {$urandom, $urandom});
        checks++;
        if (dout !== exp_dout || dv !== exp_dv || eof !== exp_eof || (exp_dv && dst !== exp_dst)) begin
          errors++;
          $display("FAIL random: got dout=%0h dv=%b eof=%b dst=%0d, want dout=%0h dv=%b eof=%b dst=%0d",
                   dout, dv, eof, dst, exp_dout, exp_dv, exp_eof, exp_dst);
        end
        start_word = 7'($urandom_range(0, 127));
        nwords_per_pkt = 7'($urandom_range(0, 20));
        src_id = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames("default", 7, 3, 0, 2, 96, 32);
    test_frames("rotation", 100, 10, 14, 1, 20, 2);
    test_frames("zero_len", 7, 0, 3, 1, 0, 0);
    test_frames("full_cover", 0, 8, 0, 1, 128, 16);
    test_ce_gating();
    test_mid_sync();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
